// File: rtl/a1_seq_detector_pkg.sv
// rtl/a1_seq_detector_pkg.sv - shared state encoding and pattern constant for the 1101 detector
//
// Purpose: names shared by the detector RTL and its bench.
//   state_e  - 3-bit FSM state encoding, S_IDLE..S_1101
//   PATTERN  - the detected bit pattern, first bit in the MSB
package a1_seq_detector_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_11   = 3'd2,
    S_110  = 3'd3,
    S_1101 = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1101;

  // The flag is a pure function of state (Moore).
  function automatic logic is_hit(input state_e s);
    return (s == S_1101);
  endfunction

endpackage

// File: rtl/a1.sv
// rtl/a1.sv - thin wrapper mapping a1 ports onto the overlapping 1101 detector
//
// Purpose: one-to-one port wrapper, OVERLAP fixed to 1.
// Ports:
//   clock   in   rising-edge system clock
//   reset   in   asynchronous active-low reset
//   bit_in  in   serial data bit
//   outFlag out  pattern-detected flag
module a1 (
  input  logic clock,
  input  logic reset,
  input  logic bit_in,
  output logic outFlag
);

  a1_seq_detector #(
    .OVERLAP(1'b1)
  ) u_det (
    .clock  (clock),
    .reset  (reset),
    .bit_in (bit_in),
    .outFlag(outFlag)
  );

endmodule

// File: rtl/a1_seq_detector.sv
// rtl/a1_seq_detector.sv - Moore serial detector for the pattern 1-1-0-1
//
// Purpose: samples one bit per rising clock edge and raises outFlag for one
// cycle each time 1101 completes. OVERLAP=1 lets the trailing 1 of a hit
// start the next pattern; OVERLAP=0 restarts after every hit.
// Ports:
//   clock   in   rising-edge system clock
//   reset   in   asynchronous active-low reset
//   bit_in  in   serial data bit
//   outFlag out  pattern-detected flag, decoded from state only
module a1_seq_detector
  import a1_seq_detector_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic bit_in,
  output logic outFlag
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = bit_in ? S_1    : S_IDLE;
      S_1:    state_d = bit_in ? S_11   : S_IDLE;
      // A further 1 keeps the last two bits as "11".
      S_11:   state_d = bit_in ? S_11   : S_110;
      S_110:  state_d = bit_in ? S_1101 : S_IDLE;
      // After a hit the trailing 1 plus a new 1 already form "11" when overlapping.
      S_1101: state_d = bit_in ? (OVERLAP ? S_11 : S_1) : S_IDLE;
      // Unused encodings fall back to idle on the next edge.
      default: state_d = S_IDLE;
    endcase
  end

  assign outFlag = is_hit(state_q);

endmodule

// File: tb/tb_a1_seq_detector.sv
// tb/tb_a1_seq_detector.sv - directed scoreboard bench for a1_seq_detector, both OVERLAP settings
module tb_a1_seq_detector;
  import a1_seq_detector_pkg::*;

  logic clock;
  logic reset;
  logic bit_in;
  logic flag_ov;
  logic flag_no;

  int tests;
  int fails;

  logic exp_ov_q[$];
  logic exp_no_q[$];

  a1_seq_detector #(.OVERLAP(1'b1)) dut_ov (
    .clock  (clock),
    .reset  (reset),
    .bit_in (bit_in),
    .outFlag(flag_ov)
  );

  a1_seq_detector #(.OVERLAP(1'b0)) dut_no (
    .clock  (clock),
    .reset  (reset),
    .bit_in (bit_in),
    .outFlag(flag_no)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one bit mid-cycle, queue the flag each DUT must show after the
  // sampling edge, then pop and compare just after that edge.
  task automatic apply_bit(input string tag, input logic b, input logic e_ov, input logic e_no);
    logic x_ov;
    logic x_no;
    @(negedge clock);
    bit_in = b;
    exp_ov_q.push_back(e_ov);
    exp_no_q.push_back(e_no);
    @(posedge clock);
    #1;
    x_ov = exp_ov_q.pop_front();
    x_no = exp_no_q.pop_front();
    check({tag, "_ov"}, flag_ov, x_ov);
    check({tag, "_no"}, flag_no, x_no);
  endtask

  // Reset held low two cycles, released at a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset  = 1'b0;
    bit_in = 1'b0;
    #1;
    check({tag, "_rst_ov"}, flag_ov, 1'b0);
    check({tag, "_rst_no"}, flag_no, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] pat;
    tests  = 0;
    fails  = 0;
    reset  = 1'b0;
    bit_in = 1'b0;
    #1;
    check("por_ov", flag_ov, 1'b0);
    check("por_no", flag_no, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Scenario 1: 0,1,0,1
    apply_bit("s1_b1", 1'b0, 1'b0, 1'b0);
    apply_bit("s1_b2", 1'b1, 1'b0, 1'b0);
    apply_bit("s1_b3", 1'b0, 1'b0, 1'b0);
    apply_bit("s1_b4", 1'b1, 1'b0, 1'b0);
    do_reset("s2");

    // Scenario 2: 0,0
    apply_bit("s2_b1", 1'b0, 1'b0, 1'b0);
    apply_bit("s2_b2", 1'b0, 1'b0, 1'b0);
    do_reset("s3");

    // Scenario 3: PATTERN MSB first, then a 0 to show the flag lasts one cycle
    pat = PATTERN;
    apply_bit("s3_b1", pat[3], 1'b0, 1'b0);
    apply_bit("s3_b2", pat[2], 1'b0, 1'b0);
    apply_bit("s3_b3", pat[1], 1'b0, 1'b0);
    apply_bit("s3_b4", pat[0], 1'b1, 1'b1);
    apply_bit("s3_b5", 1'b0, 1'b0, 1'b0);
    do_reset("s4");

    // Scenario 4: 1,1,0,0,1,1
    apply_bit("s4_b1", 1'b1, 1'b0, 1'b0);
    apply_bit("s4_b2", 1'b1, 1'b0, 1'b0);
    apply_bit("s4_b3", 1'b0, 1'b0, 1'b0);
    apply_bit("s4_b4", 1'b0, 1'b0, 1'b0);
    apply_bit("s4_b5", 1'b1, 1'b0, 1'b0);
    apply_bit("s4_b6", 1'b1, 1'b0, 1'b0);
    do_reset("s5");

    // Scenario 5: 1,1,0,1,1,0,1 - second hit only when overlapping
    apply_bit("s5_b1", 1'b1, 1'b0, 1'b0);
    apply_bit("s5_b2", 1'b1, 1'b0, 1'b0);
    apply_bit("s5_b3", 1'b0, 1'b0, 1'b0);
    apply_bit("s5_b4", 1'b1, 1'b1, 1'b1);
    apply_bit("s5_b5", 1'b1, 1'b0, 1'b0);
    apply_bit("s5_b6", 1'b0, 1'b0, 1'b0);
    apply_bit("s5_b7", 1'b1, 1'b1, 1'b0);
    apply_bit("s5_b8", 1'b0, 1'b0, 1'b0);
    do_reset("s6");

    // Scenario 6: 1,1,0 then async reset mid-cycle, release, then 1
    apply_bit("s6_b1", 1'b1, 1'b0, 1'b0);
    apply_bit("s6_b2", 1'b1, 1'b0, 1'b0);
    apply_bit("s6_b3", 1'b0, 1'b0, 1'b0);
    #4;
    reset = 1'b0;
    #1;
    check("s6_async_ov", flag_ov, 1'b0);
    check("s6_async_no", flag_no, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    apply_bit("s6_b4", 1'b1, 1'b0, 1'b0);
    apply_bit("s6_b5", 1'b0, 1'b0, 1'b0);
    do_reset("s7");

    // Scenario 7: async reset while the flag is high clears it with no clock edge
    apply_bit("s7_b1", 1'b1, 1'b0, 1'b0);
    apply_bit("s7_b2", 1'b1, 1'b0, 1'b0);
    apply_bit("s7_b3", 1'b0, 1'b0, 1'b0);
    apply_bit("s7_b4", 1'b1, 1'b1, 1'b1);
    #4;
    reset = 1'b0;
    #1;
    check("s7_async_ov", flag_ov, 1'b0);
    check("s7_async_no", flag_no, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    apply_bit("s7_b5", 1'b1, 1'b0, 1'b0);
    apply_bit("s7_b6", 1'b0, 1'b0, 1'b0);

    tests++;
    assert (exp_ov_q.size() + exp_no_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain observed=%0d expected=0", exp_ov_q.size() + exp_no_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
